// File: rtl/sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sprite_motion_ctrl
// Description : Per-frame sprite position source for the 640x480 VGA sprite
//               driver. It produces the top-left H/V offsets of a 128x128
//               sprite inside the active area. The offsets are updated only
//               on the vsync falling edge, so a frame never shows a torn
//               sprite. Two motion modes are supported: auto-bounce and
//               manual 4-button movement.
//               Optional build macro SPRITE_DEBOUNCE_EN adds a counter
//               debouncer on each synchronised button.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_motion_ctrl #(
   parameter int C_ACT_W     = 640,
   parameter int C_ACT_H     = 480,
   parameter int C_IMG_W     = 128,
   parameter int C_IMG_H     = 128,
   parameter int C_STEP      = 2,
   parameter int C_INIT_X    = 256,
   parameter int C_INIT_Y    = 128,
   parameter int C_DB_CYCLES = 1000000
) (
   input  logic       I_clk,
   input  logic       I_rst_n,
   input  logic       I_vs,
   input  logic       I_auto,
   input  logic       I_btn_up,
   input  logic       I_btn_down,
   input  logic       I_btn_left,
   input  logic       I_btn_right,
   output logic [9:0] O_h_offset,
   output logic [9:0] O_v_offset,
   output logic       O_update
);

   localparam logic signed [10:0] C_MAX_X  = 11'(C_ACT_W - C_IMG_W);
   localparam logic signed [10:0] C_MAX_Y  = 11'(C_ACT_H - C_IMG_H);
   localparam logic signed [10:0] C_STEP_S = 11'(C_STEP);
   localparam logic [9:0]         C_X0     = 10'(C_INIT_X);
   localparam logic [9:0]         C_Y0     = 10'(C_INIT_Y);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_COMMIT  = 2'd2
   } state_t;

   state_t     state_q, state_d;

   // Synchroniser bits: [0]=vs [1]=auto [2]=up [3]=down [4]=left [5]=right
   logic [5:0] sync1_q, sync2_q;
   logic       vs_prev_q;
   logic       tick;
   logic [3:0] btn;             // [0]=up [1]=down [2]=left [3]=right

   logic [9:0] h_q, v_q;        // committed offsets
   logic       dir_x_q, dir_y_q; // 1 = moving towards 0
   logic       upd_q;

   logic [9:0] nx_d, ny_d, nx_q, ny_q;
   logic       ndx_d, ndy_d, ndx_q, ndy_q;

   // Auto-bounce step on one axis; returns {new_dir, new_offset}.
   function automatic logic [10:0] step_auto(input logic [9:0]        off,
                                             input logic              dir_neg,
                                             input logic signed [10:0] maxv);
      logic signed [10:0] cand;
      cand = $signed({1'b0, off}) + (dir_neg ? -C_STEP_S : C_STEP_S);
      if (cand > maxv)
         return {1'b1, maxv[9:0]};
      else if (cand < 0)
         return {1'b0, 10'd0};
      else if ((cand == maxv) || (cand == 0))
         return {~dir_neg, cand[9:0]};
      else
         return {dir_neg, cand[9:0]};
   endfunction

   // Manual step on one axis with saturation; opposing buttons cancel.
   function automatic logic [9:0] step_man(input logic [9:0]         off,
                                           input logic               dec,
                                           input logic               inc,
                                           input logic signed [10:0] maxv);
      logic signed [10:0] cand;
      cand = $signed({1'b0, off});
      if (dec == inc)
         return off;
      else if (dec) begin
         cand = cand - C_STEP_S;
         return (cand < 0) ? 10'd0 : cand[9:0];
      end else begin
         cand = cand + C_STEP_S;
         return (cand > maxv) ? maxv[9:0] : cand[9:0];
      end
   endfunction

   // Two-flop synchronisers for vsync, mode and buttons, plus vsync history.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         vs_prev_q <= 1'b0;
      end else begin
         sync1_q   <= {I_btn_right, I_btn_left, I_btn_down, I_btn_up, I_auto, I_vs};
         sync2_q   <= sync1_q;
         vs_prev_q <= sync2_q[0];
      end
   end

   assign tick = vs_prev_q & ~sync2_q[0];

`ifdef SPRITE_DEBOUNCE_EN
   localparam int C_DB_W = (C_DB_CYCLES > 1) ? $clog2(C_DB_CYCLES) : 1;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_db
         logic [C_DB_W-1:0] cnt_q;
         logic              acc_q;

         // Accept a new button level only after it has been stable long enough.
         always_ff @(posedge I_clk or negedge I_rst_n) begin
            if (!I_rst_n) begin
               cnt_q <= '0;
               acc_q <= 1'b0;
            end else if (sync2_q[gi+2] == acc_q) begin
               cnt_q <= '0;
            end else if (cnt_q == C_DB_W'(C_DB_CYCLES - 1)) begin
               acc_q <= sync2_q[gi+2];
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         assign btn[gi] = acc_q;
      end
   endgenerate
`else
   // Without debouncing the synchronised buttons are used directly; the
   // debounce length only shapes the elaboration of this path.
   generate
      if (C_DB_CYCLES >= 0) begin : g_btn_direct
         assign btn = sync2_q[5:2];
      end else begin : g_btn_direct_alt
         assign btn = sync2_q[5:2];
      end
   endgenerate
`endif

   // Frame FSM state register.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Frame FSM next state: ticks arriving outside IDLE are ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (tick) state_d = S_COMPUTE;
         S_COMPUTE: state_d = S_COMMIT;
         S_COMMIT:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Candidate offsets and directions from the current position and mode.
   always_comb begin
      {ndx_d, nx_d} = step_auto(h_q, dir_x_q, C_MAX_X);
      {ndy_d, ny_d} = step_auto(v_q, dir_y_q, C_MAX_Y);
      if (!sync2_q[1]) begin
         nx_d  = step_man(h_q, btn[2], btn[3], C_MAX_X);
         ny_d  = step_man(v_q, btn[0], btn[1], C_MAX_Y);
         ndx_d = dir_x_q;
         ndy_d = dir_y_q;
      end
   end

   // Capture the candidates while in COMPUTE.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         nx_q  <= '0;
         ny_q  <= '0;
         ndx_q <= 1'b0;
         ndy_q <= 1'b0;
      end else if (state_q == S_COMPUTE) begin
         nx_q  <= nx_d;
         ny_q  <= ny_d;
         ndx_q <= ndx_d;
         ndy_q <= ndy_d;
      end
   end

   // Commit offsets and directions, pulsing the update flag for one cycle.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         h_q     <= C_X0;
         v_q     <= C_Y0;
         dir_x_q <= 1'b0;
         dir_y_q <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         upd_q <= (state_q == S_COMMIT);
         if (state_q == S_COMMIT) begin
            h_q     <= nx_q;
            v_q     <= ny_q;
            dir_x_q <= ndx_q;
            dir_y_q <= ndy_q;
         end
      end
   end

   assign O_h_offset = h_q;
   assign O_v_offset = v_q;
   assign O_update   = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_motion_ctrl
// Description : Self-checking bench for sprite_motion_ctrl. Two instances are
//               used: one at the default start position and one starting at
//               (1,351) to reach the saturation and bounce corners quickly.
//               Build macro SPRITE_DEBOUNCE_EN enables the debounce sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_motion_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vs[2], au[2], bu[2], bd[2], bl[2], br[2];
   logic [9:0] h[2], v[2];
   logic       upd[2];

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      int eh;
      int ev;
      int due;
   } exp_t;

   typedef struct {
      int inst;
      int a, u, d, l, r;
      int eh, ev;
   } vec_t;

   exp_t q0[$];
   exp_t q1[$];
   vec_t tbl[14];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   sprite_motion_ctrl #(.C_DB_CYCLES(16)) dut0 (
      .I_clk(clk), .I_rst_n(rst_n), .I_vs(vs[0]), .I_auto(au[0]),
      .I_btn_up(bu[0]), .I_btn_down(bd[0]), .I_btn_left(bl[0]), .I_btn_right(br[0]),
      .O_h_offset(h[0]), .O_v_offset(v[0]), .O_update(upd[0])
   );

   sprite_motion_ctrl #(.C_INIT_X(1), .C_INIT_Y(351), .C_DB_CYCLES(16)) dut1 (
      .I_clk(clk), .I_rst_n(rst_n), .I_vs(vs[1]), .I_auto(au[1]),
      .I_btn_up(bu[1]), .I_btn_down(bd[1]), .I_btn_left(bl[1]), .I_btn_right(br[1]),
      .O_h_offset(h[1]), .O_v_offset(v[1]), .O_update(upd[1])
   );

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Scoreboard and hold monitor for instance 0.
   int lh0, lv0;
   bit pr0 = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (upd[0]) begin
         if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL upd0: got pulse, expected none");
         end else begin
            e = q0.pop_front();
            chk("h0", int'(h[0]), e.eh);
            chk("v0", int'(v[0]), e.ev);
            chk("lat0", cyc, e.due);
         end
      end else if (rst_n && pr0) begin
         chk("hold_h0", int'(h[0]), lh0);
         chk("hold_v0", int'(v[0]), lv0);
      end
      lh0 = int'(h[0]); lv0 = int'(v[0]); pr0 = rst_n;
   end

   // Scoreboard and hold monitor for instance 1.
   int lh1, lv1;
   bit pr1 = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (upd[1]) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL upd1: got pulse, expected none");
         end else begin
            e = q1.pop_front();
            chk("h1", int'(h[1]), e.eh);
            chk("v1", int'(v[1]), e.ev);
            chk("lat1", cyc, e.due);
         end
      end else if (rst_n && pr1) begin
         chk("hold_h1", int'(h[1]), lh1);
         chk("hold_v1", int'(v[1]), lv1);
      end
      lh1 = int'(h[1]); lv1 = int'(v[1]); pr1 = rst_n;
   end

   task automatic push_exp(input int i, input int eh, input int ev);
      exp_t e;
      e.eh = eh; e.ev = ev; e.due = cyc + 5;
      if (i == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic drain(input int i);
      if (i == 0) begin
         chk("drain0", q0.size(), 0);
         q0.delete();
      end else begin
         chk("drain1", q1.size(), 0);
         q1.delete();
      end
   endtask

   // One frame: set mode/buttons, let them settle, drop vsync, expect a commit.
   task automatic frame(input int i, input int a, input int u, input int d,
                        input int l, input int r, input int eh, input int ev);
      @(negedge clk);
      au[i] = a[0]; bu[i] = u[0]; bd[i] = d[0]; bl[i] = l[0]; br[i] = r[0];
      repeat (30) @(negedge clk);
      vs[i] = 1'b0;
      push_exp(i, eh, ev);
      repeat (10) @(negedge clk);
      vs[i] = 1'b1;
      drain(i);
      repeat (5) @(negedge clk);
   endtask

   initial begin
      //               inst a  u  d  l  r   eh   ev
      tbl[0]  = '{0,   1, 0, 0, 0, 0, 258, 130};
      tbl[1]  = '{0,   1, 0, 0, 0, 0, 260, 132};
      tbl[2]  = '{0,   0, 0, 0, 1, 0, 258, 132};
      tbl[3]  = '{0,   0, 1, 1, 0, 1, 260, 132};
      tbl[4]  = '{0,   0, 0, 1, 1, 1, 260, 134};
      tbl[5]  = '{0,   1, 0, 0, 0, 0, 262, 136};
      tbl[6]  = '{0,   0, 1, 0, 0, 0, 262, 134};
      tbl[7]  = '{1,   0, 0, 0, 1, 0,   0, 351};
      tbl[8]  = '{1,   0, 0, 0, 1, 0,   0, 351};
      tbl[9]  = '{1,   0, 1, 1, 0, 0,   0, 351};
      tbl[10] = '{1,   1, 0, 0, 0, 0,   2, 352};
      tbl[11] = '{1,   1, 0, 0, 0, 0,   4, 350};
      tbl[12] = '{1,   0, 0, 1, 0, 1,   6, 352};
      tbl[13] = '{1,   1, 0, 0, 0, 0,   8, 350};

      for (int i = 0; i < 2; i++) begin
         vs[i] = 1'b1; au[i] = 1'b1;
         bu[i] = 1'b0; bd[i] = 1'b0; bl[i] = 1'b0; br[i] = 1'b0;
      end

      // Reset values, then a long quiet period with no vsync edges.
      repeat (3) @(negedge clk);
      chk("rst_h0", int'(h[0]), 256);
      chk("rst_v0", int'(v[0]), 128);
      chk("rst_upd0", int'(upd[0]), 0);
      chk("rst_h1", int'(h[1]), 1);
      chk("rst_v1", int'(v[1]), 351);
      rst_n = 1'b1;
      repeat (2000) @(negedge clk);
      chk("idle_h0", int'(h[0]), 256);
      chk("idle_v0", int'(v[0]), 128);

      // Table-driven frames.
      for (int k = 0; k < 14; k++)
         frame(tbl[k].inst, tbl[k].a, tbl[k].u, tbl[k].d, tbl[k].l, tbl[k].r,
               tbl[k].eh, tbl[k].ev);

`ifdef SPRITE_DEBOUNCE_EN
      // Short right glitch must not move the sprite.
      @(negedge clk);
      au[0] = 1'b0; bu[0] = 1'b0; bd[0] = 1'b0; bl[0] = 1'b0;
      br[0] = 1'b1;
      repeat (10) @(negedge clk);
      br[0] = 1'b0;
      repeat (40) @(negedge clk);
      frame(0, 0, 0, 0, 0, 0, 262, 134);

      // A 20-cycle press spanning the tick is accepted.
      @(negedge clk);
      br[0] = 1'b1;
      repeat (18) @(negedge clk);
      vs[0] = 1'b0;
      push_exp(0, 264, 134);
      repeat (2) @(negedge clk);
      br[0] = 1'b0;
      repeat (8) @(negedge clk);
      vs[0] = 1'b1;
      drain(0);
      repeat (40) @(negedge clk);
`endif

      // Reset asserted while instance 0 is in COMPUTE: no commit pulse.
      @(negedge clk);
      vs[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_h0", int'(h[0]), 256);
      chk("midrst_v0", int'(v[0]), 128);
      chk("midrst_upd0", int'(upd[0]), 0);
      chk("midrst_h1", int'(h[1]), 1);
      chk("midrst_v1", int'(v[1]), 351);
      @(negedge clk);
      vs[0] = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_rst_h0", int'(h[0]), 256);

      // Directions restart at +1 after reset.
      frame(0, 1, 0, 0, 0, 0, 258, 130);
      frame(1, 1, 0, 0, 0, 0, 3, 352);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
